// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RISC-V M-extension mul/div engine; define MULDIV_RESULT_CACHE_EN to add a last-divide result cache
module muldiv_iter #(
  parameter int XLEN      = 32,
  parameter int MUL_STEPS = 1,
  parameter int DIV_STEPS = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);
  localparam int N_MUL = XLEN / MUL_STEPS;
  localparam int N_DIV = XLEN / DIV_STEPS;
  localparam int CW    = $clog2(XLEN + 1);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t                    state_q, state_d;
  logic [2:0]                op_q, op_d;
  logic                      neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]           opnd_q, opnd_d, res_q, res_d;
  logic [2*XLEN-1:0]         acc_q, acc_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      sa, sb, div_zero, ovf, hit;
  logic [XLEN-1:0]           ma, mb, quo, rem, hit_res;
  logic [XLEN+MUL_STEPS-1:0] msum;
  logic [2*XLEN+MUL_STEPS-1:0] mshift;
  logic [2*XLEN-1:0]         dr, prod;
  logic [XLEN:0]             full, diff;

  // operand conditioning, one mul/div iteration, sign fix-up and next-state selection
  always_comb begin
    sa       = a_i[XLEN-1] & (op_i[2] ? ~op_i[0] : op_i[1:0] != 2'd3);
    sb       = b_i[XLEN-1] & (op_i[2] ? ~op_i[0] : ~op_i[1]);
    ma       = sa ? -a_i : a_i;
    mb       = sb ? -b_i : b_i;
    div_zero = op_i[2] && b_i == '0;
    ovf      = op_i[2] && !op_i[0] && a_i == {1'b1, {(XLEN-1){1'b0}}} && b_i == '1;
    msum     = (XLEN+MUL_STEPS)'(acc_q[2*XLEN-1:XLEN]) + (XLEN+MUL_STEPS)'(opnd_q) * (XLEN+MUL_STEPS)'(acc_q[MUL_STEPS-1:0]);
    mshift   = {msum, acc_q[XLEN-1:0]};
    dr       = acc_q;
    full     = '0;
    diff     = '0;
    for (int i = 0; i < DIV_STEPS; i++) begin
      full = dr[2*XLEN-1:XLEN-1];
      diff = full - {1'b0, opnd_q};
      dr   = {diff[XLEN] ? full[XLEN-1:0] : diff[XLEN-1:0], dr[XLEN-2:0], ~diff[XLEN]};
    end
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem     = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (flush_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (valid_i) begin
        op_d    = op_i;
        neg_d   = sa ^ sb;
        rneg_d  = sa;
        opnd_d  = op_i[2] ? mb : ma;
        acc_d   = {{XLEN{1'b0}}, op_i[2] ? ma : mb};
        cnt_d   = op_i[2] ? CW'(N_DIV - 1) : CW'(N_MUL - 1);
        state_d = op_i[2] ? DIV : MUL;
        if (div_zero || ovf || hit) begin
          res_d   = div_zero ? (op_i[1] ? a_i : {XLEN{1'b1}}) : ovf ? (op_i[1] ? {XLEN{1'b0}} : a_i) : hit_res;
          state_d = DONE;
        end
      end
      MUL: begin
        acc_d   = mshift[2*XLEN+MUL_STEPS-1:MUL_STEPS];
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? FIX : MUL;
      end
      DIV: begin
        acc_d   = dr;
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? FIX : DIV;
      end
      FIX: begin
        res_d   = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
        state_d = DONE;
      end
      default: state_d = ready_i ? IDLE : DONE;
    endcase
  end

  // engine registers; reset lands in IDLE with the result cleared
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

`ifdef MULDIV_RESULT_CACHE_EN
  logic            c_wr, c_vld_q, c_vld_d, c_sgn_q, c_sgn_d;
  logic [XLEN-1:0] ka_q, ka_d, kb_q, kb_d, c_a_q, c_a_d, c_b_q, c_b_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;

  // hold the raw operands of the running op and store the entry when a divide leaves FIX
  always_comb begin
    ka_d    = state_q == IDLE ? a_i : ka_q;
    kb_d    = state_q == IDLE ? b_i : kb_q;
    c_wr    = state_q == FIX && op_q[2] && !flush_i;
    c_vld_d = c_vld_q | c_wr;
    c_sgn_d = c_wr ? ~op_q[0] : c_sgn_q;
    c_a_d   = c_wr ? ka_q : c_a_q;
    c_b_d   = c_wr ? kb_q : c_b_q;
    c_quo_d = c_wr ? quo : c_quo_q;
    c_rem_d = c_wr ? rem : c_rem_q;
  end

  assign hit     = op_i[2] && c_vld_q && c_sgn_q == ~op_i[0] && c_a_q == a_i && c_b_q == b_i;
  assign hit_res = op_i[1] ? c_rem_q : c_quo_q;

  // cache registers; reset invalidates the entry
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ka_q    <= '0;
      kb_q    <= '0;
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
    end else begin
      ka_q    <= ka_d;
      kb_q    <= kb_d;
      c_vld_q <= c_vld_d;
      c_sgn_q <= c_sgn_d;
      c_a_q   <= c_a_d;
      c_b_q   <= c_b_d;
      c_quo_q <= c_quo_d;
      c_rem_q <= c_rem_d;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  assign ready_o  = state_q == IDLE;
  assign busy_o   = state_q != IDLE;
  assign valid_o  = state_q == DONE;
  assign result_o = res_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed vector table plus back-pressure, flush, cache and reset sequences
module tb_muldiv_iter;
`ifdef MULDIV_RESULT_CACHE_EN
  localparam int HL = 1;
`else
  localparam int HL = 18;
`endif
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] result_o;
  logic        busy_o;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[18];

  muldiv_iter #(.XLEN(32), .MUL_STEPS(1), .DIV_STEPS(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; ready_i = 1'b0;
    @(posedge clk); #1;
    valid_i = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_o;
    @(negedge clk); ready_i = 1'b1;
    @(posedge clk); #1; ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          l;
    logic        seen;
    vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 34};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34};
    vecs[3]  = '{3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 34};
    vecs[4]  = '{3'd0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 34};
    vecs[5]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[6]  = '{3'd2, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 34};
    vecs[7]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[8]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 18};
    vecs[9]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, HL};
    vecs[10] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 18};
    vecs[11] = '{3'd6, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, HL};
    vecs[12] = '{3'd5, 32'd100,      32'd7,        32'd14,       18};
    vecs[13] = '{3'd7, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 18};
    vecs[14] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[15] = '{3'd6, 32'd5,        32'd0,        32'd5,        1};
    vecs[16] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[17] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset ready_o", 32'(ready_o), 32'd1);
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset busy_o", 32'(busy_o), 32'd0);
    chk("reset result_o", result_o, 32'd0);
    @(negedge clk); rst_i = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, l);
      chk($sformatf("vec%0d result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), 32'(l), 32'(vecs[i].lat));
    end

    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd3; a_i = 32'hFFFFFFFF; b_i = 32'h2;
    @(posedge clk); #1;
    valid_i = 1'b0;
    l = 1;
    while (!valid_o && l < 100) begin
      @(posedge clk); #1;
      l++;
    end
    chk("bp latency", 32'(l), 32'd34);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp result c%0d", i), result_o, 32'h1);
      chk($sformatf("bp ready_o c%0d", i), 32'(ready_o), 32'd0);
    end
    @(negedge clk); ready_i = 1'b1;
    @(posedge clk); #1; ready_i = 1'b0;
    chk("bp release ready_o", 32'(ready_o), 32'd1);

    run_op(3'd4, 32'd1000, 32'd7, r, l);
    chk("c div result", r, 32'd142);
    chk("c div latency", 32'(l), 32'd18);
    run_op(3'd6, 32'd1000, 32'd7, r, l);
    chk("c rem result", r, 32'd6);
    chk("c rem latency", 32'(l), 32'(HL));
    run_op(3'd7, 32'd1000, 32'd7, r, l);
    chk("c remu result", r, 32'd6);
    chk("c remu latency", 32'(l), 32'd18);

    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd4; a_i = 32'd1000; b_i = 32'd9;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1; valid_i = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd3;
    @(posedge clk); #1;
    chk("flush busy_o", 32'(busy_o), 32'd0);
    chk("flush ready_o", 32'(ready_o), 32'd1);
    chk("flush valid_o", 32'(valid_o), 32'd0);
    @(negedge clk); flush_i = 1'b0; valid_i = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      seen = seen | valid_o | busy_o;
    end
    chk("flush quiet", 32'(seen), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, r, l);
    chk("post flush mul", r, 32'd12);
    run_op(3'd5, 32'd1000, 32'd7, r, l);
    chk("post flush divu result", r, 32'd142);
    chk("post flush divu latency", 32'(l), 32'(HL));

    @(negedge clk);
    valid_i = 1'b1; op_i = 3'd0; a_i = 32'd7; b_i = 32'd9;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk); #1;
    chk("mid rst ready_o", 32'(ready_o), 32'd1);
    chk("mid rst valid_o", 32'(valid_o), 32'd0);
    chk("mid rst busy_o", 32'(busy_o), 32'd0);
    chk("mid rst result_o", result_o, 32'd0);
    @(negedge clk); rst_i = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, r, l);
    chk("post rst mul result", r, 32'd12);
    chk("post rst mul latency", 32'(l), 32'd34);
    run_op(3'd5, 32'd1000, 32'd7, r, l);
    chk("post rst divu result", r, 32'd142);
    chk("post rst divu latency", 32'(l), 32'd18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
